// File: rtl/temp_bcd_converter.sv
// Sequential binary-to-BCD stage for the DS18B20 temperature word: iterative double-dabble
// on the integer field plus a tenths digit derived from the 1/16 degC fraction.
module temp_bcd_converter #(
    parameter int ROUND_TENTHS = 0,
    parameter int BLANK_ZEROS  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] temp_i,
    input  logic        temp_valid_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        sign_o,
    output logic [1:0]  hundreds_o,
    output logic [3:0]  tens_o,
    output logic [3:0]  units_o,
    output logic [3:0]  tenths_o,
    output logic        hund_blank_o,
    output logic        tens_blank_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic        pend_flag;
    logic [12:0] pend_word;
    logic        sign_r;
    logic [11:0] mag_r;
    logic [9:0]  bcd;
    logic [7:0]  int_sr;
    logic [2:0]  iter;
    logic [3:0]  tenths_r;

    // Bits [14:12] only repeat the sign; only bit 15 and the low 12 bits carry information.
    logic unused_ext_bits;
    assign unused_ext_bits = ^temp_i[14:12];

    function automatic logic [11:0] magnitude(input logic [12:0] word);
        logic signed [12:0] sval;
        logic [12:0]        neg;
        sval = signed'(word);
        neg  = unsigned'(-sval);
        return word[12] ? neg[11:0] : word[11:0];
    endfunction

    function automatic logic [3:0] tenths_of(input logic [3:0] frac);
        logic [7:0] prod;
        prod = ({4'd0, frac} << 3) + ({4'd0, frac} << 1);
        if (ROUND_TENTHS != 0) begin
            prod = prod + 8'd8;
        end
        return prod[7:4];
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    // One double-dabble iteration: correct each BCD nibble, then shift {bcd, int_sr} left by one.
    function automatic logic [17:0] dabble_step(input logic [9:0] b, input logic [7:0] s);
        logic [17:0] joined;
        joined = {b[9:8], add3(b[7:4]), add3(b[3:0]), s};
        return {joined[16:0], 1'b0};
    endfunction

    assign busy_o = (state == S_LOAD) || (state == S_SHIFT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            pend_flag    <= 1'b0;
            pend_word    <= '0;
            sign_r       <= 1'b0;
            mag_r        <= '0;
            bcd          <= '0;
            int_sr       <= '0;
            iter         <= '0;
            tenths_r     <= '0;
            done_o       <= 1'b0;
            sign_o       <= 1'b0;
            hundreds_o   <= '0;
            tens_o       <= '0;
            units_o      <= '0;
            tenths_o     <= '0;
            hund_blank_o <= 1'b0;
            tens_blank_o <= 1'b0;
        end else begin
            done_o <= 1'b0;

            // A strobe arriving while a conversion is in flight is parked; the newest one wins.
            if (temp_valid_i && (state != S_IDLE)) begin
                pend_flag <= 1'b1;
                pend_word <= {temp_i[15], temp_i[11:0]};
            end

            case (state)
                S_IDLE: begin
                    if (temp_valid_i) begin
                        sign_r    <= temp_i[15];
                        mag_r     <= magnitude({temp_i[15], temp_i[11:0]});
                        pend_flag <= 1'b0;
                        state     <= S_LOAD;
                    end else if (pend_flag) begin
                        sign_r    <= pend_word[12];
                        mag_r     <= magnitude(pend_word);
                        pend_flag <= 1'b0;
                        state     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    bcd      <= '0;
                    int_sr   <= mag_r[11:4];
                    iter     <= '0;
                    tenths_r <= tenths_of(mag_r[3:0]);
                    state    <= S_SHIFT;
                end

                S_SHIFT: begin
                    {bcd, int_sr} <= dabble_step(bcd, int_sr);
                    iter          <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done_o       <= 1'b1;
                    // A value that displays as 0.0 is shown unsigned.
                    sign_o       <= sign_r && !((bcd == 10'd0) && (tenths_r == 4'd0));
                    hundreds_o   <= bcd[9:8];
                    tens_o       <= bcd[7:4];
                    units_o      <= bcd[3:0];
                    tenths_o     <= tenths_r;
                    hund_blank_o <= (BLANK_ZEROS != 0) && (bcd[9:8] == 2'd0);
                    tens_blank_o <= (BLANK_ZEROS != 0) && (bcd[9:4] == 6'd0);
                    state        <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_bcd_converter.sv
// Directed bench for temp_bcd_converter: truncating and rounding instances driven in lockstep.
module tb_temp_bcd_converter;

    logic        clk;
    logic        rst;
    logic [15:0] temp;
    logic        temp_valid;

    logic       busy, done, sign, hund_blank, tens_blank;
    logic [1:0] hundreds;
    logic [3:0] tens, units, tenths;

    logic       r_busy, r_done, r_sign, r_hund_blank, r_tens_blank;
    logic [1:0] r_hundreds;
    logic [3:0] r_tens, r_units, r_tenths;

    int vectors;
    int miscompares;

    temp_bcd_converter #(.ROUND_TENTHS(0), .BLANK_ZEROS(1)) u_dut (
        .clk(clk), .rst(rst), .temp_i(temp), .temp_valid_i(temp_valid),
        .busy_o(busy), .done_o(done), .sign_o(sign), .hundreds_o(hundreds),
        .tens_o(tens), .units_o(units), .tenths_o(tenths),
        .hund_blank_o(hund_blank), .tens_blank_o(tens_blank)
    );

    temp_bcd_converter #(.ROUND_TENTHS(1), .BLANK_ZEROS(1)) u_rnd (
        .clk(clk), .rst(rst), .temp_i(temp), .temp_valid_i(temp_valid),
        .busy_o(r_busy), .done_o(r_done), .sign_o(r_sign), .hundreds_o(r_hundreds),
        .tens_o(r_tens), .units_o(r_units), .tenths_o(r_tenths),
        .hund_blank_o(r_hund_blank), .tens_blank_o(r_tens_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic s, input logic [1:0] h,
                             input logic [3:0] t, input logic [3:0] u, input logic [3:0] te,
                             input logic hb, input logic tb);
        check({tag, ".sign"},       16'(sign),       16'(s));
        check({tag, ".hundreds"},   16'(hundreds),   16'(h));
        check({tag, ".tens"},       16'(tens),       16'(t));
        check({tag, ".units"},      16'(units),      16'(u));
        check({tag, ".tenths"},     16'(tenths),     16'(te));
        check({tag, ".hund_blank"}, 16'(hund_blank), 16'(hb));
        check({tag, ".tens_blank"}, 16'(tens_blank), 16'(tb));
    endtask

    // Called #1 after an edge; returns #1 after the edge that raised done (or after the budget).
    task automatic convert(input logic [15:0] w, output int lat, output logic busy_load);
        temp       = w;
        temp_valid = 1'b1;
        @(posedge clk); #1;
        temp_valid = 1'b0;
        busy_load  = busy;
        lat        = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    int         lat;
    logic       busy_load;
    int         ndone;
    int         done_idx [2];
    logic [9:0] done_val [2];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        temp        = 16'h0000;
        temp_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 16'(busy), 16'd0);
        check("reset.done", 16'(done), 16'd0);
        check_out("reset", 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;

        convert(16'h0191, lat, busy_load);
        check("p25.latency", 16'(lat), 16'd10);
        check("p25.busy_in_load", 16'(busy_load), 16'd1);
        check("p25.busy_at_done", 16'(busy), 16'd0);
        check_out("p25", 1'b0, 2'd0, 4'd2, 4'd5, 4'd0, 1'b1, 1'b0);
        check("p25.rnd_tenths", 16'(r_tenths), 16'd1);
        @(posedge clk); #1;
        check("p25.done_one_cycle", 16'(done), 16'd0);
        check("p25.hold_units", 16'(units), 16'd5);

        convert(16'hFC90, lat, busy_load);
        check("m55.latency", 16'(lat), 16'd10);
        check_out("m55", 1'b1, 2'd0, 4'd5, 4'd5, 4'd0, 1'b1, 1'b0);

        convert(16'h07D0, lat, busy_load);
        check_out("p125", 1'b0, 2'd1, 4'd2, 4'd5, 4'd0, 1'b0, 1'b0);

        convert(16'hFFF8, lat, busy_load);
        check_out("m0p5", 1'b1, 2'd0, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1);

        convert(16'hFFFF, lat, busy_load);
        check_out("negzero", 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
        check("negzero.rnd_sign", 16'(r_sign), 16'd1);
        check("negzero.rnd_tenths", 16'(r_tenths), 16'd1);

        convert(16'h0008, lat, busy_load);
        check_out("p0p5", 1'b0, 2'd0, 4'd0, 4'd0, 4'd5, 1'b1, 1'b1);
        check("p0p5.rnd_tenths", 16'(r_tenths), 16'd5);

        convert(16'h0003, lat, busy_load);
        check("p3_16.tenths", 16'(tenths), 16'd1);
        check("p3_16.rnd_tenths", 16'(r_tenths), 16'd2);

        convert(16'hFF5E, lat, busy_load);
        check_out("m10p1", 1'b1, 2'd0, 4'd1, 4'd0, 4'd1, 1'b1, 1'b0);

        convert(16'h0FF0, lat, busy_load);
        check_out("p255", 1'b0, 2'd2, 4'd5, 4'd5, 4'd0, 1'b0, 1'b0);

        // Reset while in SHIFT iteration 4.
        temp       = 16'h0550;
        temp_valid = 1'b1;
        @(posedge clk); #1;
        temp_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid.busy_before", 16'(busy), 16'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mid.busy", 16'(busy), 16'd0);
        check("rst_mid.done", 16'(done), 16'd0);
        check_out("rst_mid", 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst   = 1'b1;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("rst_mid.no_done", 16'(ndone), 16'd0);

        convert(16'h0191, lat, busy_load);
        check("after_rst.latency", 16'(lat), 16'd10);
        check_out("after_rst", 1'b0, 2'd0, 4'd2, 4'd5, 4'd0, 1'b1, 1'b0);
        @(posedge clk); #1;

        // Strobes at +0, +3 and +5: the middle word is overwritten in the pending buffer.
        ndone = 0;
        done_idx[0] = -1; done_idx[1] = -1;
        done_val[0] = '0; done_val[1] = '0;
        for (int i = 0; i <= 30; i++) begin
            temp_valid = (i == 0) || (i == 3) || (i == 5);
            temp       = (i == 0) ? 16'h0191 : (i == 3) ? 16'h0550 : 16'h07D0;
            @(posedge clk); #1;
            temp_valid = 1'b0;
            if (done) begin
                if (ndone < 2) begin
                    done_idx[ndone] = i;
                    done_val[ndone] = {hundreds, tens, units};
                end
                ndone++;
            end
        end
        check("overlap.done_count", 16'(ndone), 16'd2);
        check("overlap.first_edge", 16'(done_idx[0]), 16'd10);
        check("overlap.first_val", 16'(done_val[0]), 16'h025);
        check("overlap.second_edge", 16'(done_idx[1]), 16'd21);
        check("overlap.second_val", 16'(done_val[1]), 16'h125);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
